// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI-Stream consumer
// between NUM_INPUTS producers. A winner owns the output until its tlast
// beat is accepted; the owning index is forwarded on m_axis_tid.
module axis_packet_arbiter #(
    parameter int NUM_INPUTS = 3,
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = $clog2(NUM_INPUTS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_INPUTS*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [NUM_INPUTS-1:0]            s_axis_tvalid,
    input  logic [NUM_INPUTS-1:0]            s_axis_tlast,
    output logic [NUM_INPUTS-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             m_axis_tlast,
    output logic [ID_WIDTH-1:0]              m_axis_tid,
    input  logic [NUM_INPUTS-1:0]            enable_mask,
    output logic                             busy,
    output logic [ID_WIDTH-1:0]              grant_idx
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ID_WIDTH-1:0]   r_grant;
    logic [ID_WIDTH-1:0]   w_grant_nxt;
    logic [ID_WIDTH-1:0]   r_rr_ptr;
    logic [ID_WIDTH-1:0]   w_rr_ptr_nxt;

    logic [NUM_INPUTS-1:0] w_req;
    logic [NUM_INPUTS-1:0] w_req_eop;
    logic [NUM_INPUTS-1:0] w_grant_onehot;
    logic                  w_others_req;
    logic [ID_WIDTH-1:0]   w_grant_inc;
    logic                  w_eop;
    logic [ID_WIDTH:0]     w_pick_idle;
    logic [ID_WIDTH:0]     w_pick_eop;

    // First set bit of req at or above start, wrapping to the bottom of the
    // vector. Result is {found, index}. Two linear passes avoid any modulo
    // arithmetic, so non-power-of-two input counts wrap at NUM_INPUTS-1.
    function automatic logic [ID_WIDTH:0] rr_pick(
        input logic [NUM_INPUTS-1:0] req,
        input logic [ID_WIDTH-1:0]   start
    );
        logic                found;
        logic [ID_WIDTH-1:0] idx;
        found = 1'b0;
        idx   = {ID_WIDTH{1'b0}};
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (!found && req[i] && (ID_WIDTH'(i) >= start)) begin
                found = 1'b1;
                idx   = ID_WIDTH'(i);
            end else begin
                found = found;
            end
        end
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (!found && req[i]) begin
                found = 1'b1;
                idx   = ID_WIDTH'(i);
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

    assign w_req       = s_axis_tvalid & enable_mask;
    assign w_grant_inc = (r_grant == ID_WIDTH'(NUM_INPUTS - 1)) ? {ID_WIDTH{1'b0}}
                                                                : r_grant + ID_WIDTH'(1);
    assign w_eop       = (r_state == ST_LOCKED) & m_axis_tvalid & m_axis_tready & m_axis_tlast;

    // At end of packet the current owner may only win again if nobody else asks.
    always_comb begin
        w_grant_onehot = {NUM_INPUTS{1'b0}};
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (r_grant == ID_WIDTH'(i)) begin
                w_grant_onehot[i] = 1'b1;
            end else begin
                w_grant_onehot[i] = 1'b0;
            end
        end
        w_others_req = |(w_req & ~w_grant_onehot);
        if (w_others_req) begin
            w_req_eop = w_req & ~w_grant_onehot;
        end else begin
            w_req_eop = w_req;
        end
    end

    assign w_pick_idle = rr_pick(w_req, r_rr_ptr);
    assign w_pick_eop  = rr_pick(w_req_eop, w_grant_inc);

    // Next-state logic: grant from IDLE, re-arbitrate with no bubble at tlast.
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_rr_ptr_nxt = r_rr_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_idle[ID_WIDTH]) begin
                    w_state_nxt = ST_LOCKED;
                    w_grant_nxt = w_pick_idle[ID_WIDTH-1:0];
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (w_eop) begin
                    w_rr_ptr_nxt = w_grant_inc;
                    if (w_pick_eop[ID_WIDTH]) begin
                        w_state_nxt = ST_LOCKED;
                        w_grant_nxt = w_pick_eop[ID_WIDTH-1:0];
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_LOCKED;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_grant  <= {ID_WIDTH{1'b0}};
            r_rr_ptr <= {ID_WIDTH{1'b0}};
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

    // Datapath mux: forward the granted lane; all outputs idle outside LOCKED.
    always_comb begin
        m_axis_tdata  = {DATA_WIDTH{1'b0}};
        m_axis_tkeep  = {KEEP_WIDTH{1'b0}};
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = {NUM_INPUTS{1'b0}};
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if ((r_state == ST_LOCKED) && (r_grant == ID_WIDTH'(i))) begin
                m_axis_tdata     = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                m_axis_tkeep     = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
                m_axis_tvalid    = s_axis_tvalid[i];
                m_axis_tlast     = s_axis_tlast[i];
                s_axis_tready[i] = m_axis_tready;
            end else begin
                s_axis_tready[i] = 1'b0;
            end
        end
    end

    assign m_axis_tid = r_grant;
    assign grant_idx  = r_grant;
    assign busy       = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Randomized bench for axis_packet_arbiter with a transaction-level model
// of packet ownership and round-robin order.
module tb_axis_packet_arbiter;

    localparam int N  = 3;
    localparam int DW = 8;
    localparam int KW = 1;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*DW-1:0] s_tdata;
    logic [N*KW-1:0] s_tkeep;
    logic [N-1:0]    s_tvalid;
    logic [N-1:0]    s_tlast;
    logic [N-1:0]    s_tready;
    logic [DW-1:0]   m_tdata;
    logic [KW-1:0]   m_tkeep;
    logic            m_tvalid;
    logic            m_tready;
    logic            m_tlast;
    logic [IW-1:0]   m_tid;
    logic [N-1:0]    enable_mask;
    logic            busy;
    logic [IW-1:0]   grant_idx;

    always #5 clk = ~clk;

    axis_packet_arbiter #(
        .NUM_INPUTS(N), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(IW)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tid(m_tid),
        .enable_mask(enable_mask), .busy(busy), .grant_idx(grant_idx)
    );

    int total = 0;
    int bad   = 0;

    // Source generators
    int       len [N];
    int       beat[N];
    int       pcnt[N];
    logic [N-1:0] vld_b;
    logic [N-1:0] kp_b;
    logic [N-1:0] act;
    logic [N-1:0] mask_b;
    logic         mrdy;
    int p_valid, p_ready, p_mask_chg, fix_len;

    // Reference model: owner = -1 means nobody holds the output
    int owner, ptr, gidx;
    logic [N-1:0] hs;
    int tid_q[$];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] beat_data(input int i);
        return 8'(i * 64 + (pcnt[i] % 8) * 8 + beat[i]);
    endfunction

    function automatic logic is_last(input int i);
        return beat[i] == len[i] - 1;
    endfunction

    task automatic new_pkt(input int i);
        len[i]  = (fix_len != 0) ? fix_len : int'($urandom_range(1, 4));
        beat[i] = 0;
        pcnt[i] = pcnt[i] + 1;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            s_tdata[i*DW +: DW] = beat_data(i);
            s_tkeep[i]          = kp_b[i];
            s_tvalid[i]         = vld_b[i];
            s_tlast[i]          = is_last(i);
        end
        enable_mask = mask_b;
        m_tready    = mrdy;
    endtask

    task automatic idle_checks(input string tag);
        chk_eq({tag, "_tready"}, 32'(s_tready), 32'd0);
        chk_eq({tag, "_mvalid"}, 32'(m_tvalid), 32'd0);
        chk_eq({tag, "_busy"},   32'(busy),     32'd0);
        chk_eq({tag, "_gidx"},   32'(grant_idx), 32'd0);
    endtask

    // Assert reset now (mid-cycle), all active sources valid, release later.
    task automatic do_reset(input int cyc);
        rst   = 1'b0;
        owner = -1;
        ptr   = 0;
        gidx  = 0;
        for (int i = 0; i < N; i++) begin
            new_pkt(i);
            vld_b[i] = act[i];
            kp_b[i]  = 1'($urandom);
        end
        mask_b = '1;
        mrdy   = 1'b1;
        drive();
        #1;
        idle_checks("rst_async");
        repeat (cyc) begin
            @(negedge clk);
            idle_checks("rst_hold");
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic step();
        logic [N-1:0] rq;
        logic [N-1:0] etr;
        int nxt, j, g;
        @(negedge clk);
        etr = '0;
        if (owner >= 0 && mrdy) etr[owner] = 1'b1;
        chk_eq("busy",   32'(busy),      32'(owner >= 0));
        chk_eq("gidx",   32'(grant_idx), 32'(gidx));
        chk_eq("tready", 32'(s_tready),  32'(etr));
        chk_eq("mvalid", 32'(m_tvalid),  (owner >= 0) ? 32'(vld_b[owner]) : 32'd0);
        if (owner >= 0) begin
            chk_eq("tid", 32'(m_tid), 32'(owner));
            if (vld_b[owner]) begin
                chk_eq("tdata", 32'(m_tdata), 32'(beat_data(owner)));
                chk_eq("tkeep", 32'(m_tkeep), 32'(kp_b[owner]));
                chk_eq("tlast", 32'(m_tlast), 32'(is_last(owner)));
            end
        end
        if (m_tvalid && m_tready) tid_q.push_back(int'(m_tid));
        hs = vld_b & etr;
        // Ownership update from the rules: round-robin from ptr, packet locking
        rq  = vld_b & mask_b;
        nxt = owner;
        if (owner < 0) begin
            for (int k = 0; k < N; k++) begin
                j = (ptr + k) % N;
                if (nxt < 0 && rq[j]) nxt = j;
            end
        end else if (vld_b[owner] && mrdy && is_last(owner)) begin
            g   = owner;
            ptr = (g + 1) % N;
            if ($countones(rq) > 1) rq[g] = 1'b0;
            nxt = -1;
            for (int k = 0; k < N; k++) begin
                j = (ptr + k) % N;
                if (nxt < 0 && rq[j]) nxt = j;
            end
        end
        owner = nxt;
        if (owner >= 0) gidx = owner;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                if (is_last(i)) new_pkt(i);
                else beat[i] = beat[i] + 1;
                kp_b[i]  = 1'($urandom);
                vld_b[i] = act[i] && ($urandom_range(0, 99) < p_valid);
            end else if (!vld_b[i]) begin
                vld_b[i] = act[i] && ($urandom_range(0, 99) < p_valid);
            end
        end
        mrdy = ($urandom_range(0, 99) < p_ready);
        if ($urandom_range(0, 99) < p_mask_chg) mask_b = N'($urandom);
        drive();
    endtask

    int exp_rr[8] = '{0, 0, 1, 1, 2, 2, 0, 0};

    initial begin
        for (int i = 0; i < N; i++) pcnt[i] = 0;
        rst = 1'b0;

        // Directed: reset with all valid, then continuous 2-beat round-robin
        act = '1; fix_len = 2; p_valid = 100; p_ready = 100; p_mask_chg = 0;
        do_reset(3);
        tid_q.delete();
        repeat (12) step();
        chk_eq("rr_count", 32'(tid_q.size() >= 8), 32'd1);
        for (int k = 0; k < 8 && k < tid_q.size(); k++)
            chk_eq("rr_seq", 32'(tid_q[k]), 32'(exp_rr[k]));

        // Single requester: back-to-back packets with backpressure
        act = 3'b010; fix_len = 0; p_valid = 100; p_ready = 50;
        do_reset(2);
        repeat (150) step();

        // Random traffic, gaps, backpressure and mask changes, mid-run reset
        for (int ph = 0; ph < 3; ph++) begin
            act = '1;
            p_valid    = (ph == 0) ? 90 : 60;
            p_ready    = (ph == 1) ? 40 : 80;
            p_mask_chg = (ph == 2) ? 30 : 5;
            repeat (300) step();
            do_reset(2);
            repeat (300) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_packet_arbiter.md
Name: axis_packet_arbiter

Overview:
- Shares one downstream AXI-Stream consumer (typically the width adapter feeding the USB/UART link) between NUM_INPUTS upstream AXIS producers.
- Arbitration is round-robin at packet granularity: once a requester wins, it owns the output until its tlast beat is accepted. Packets are never interleaved.
- The winning port index is presented on m_axis_tid, so the packet source is recoverable after width conversion.

Parameters:
- NUM_INPUTS, 3, number of requesting AXIS sinks (2..8).
- DATA_WIDTH, 8, tdata width per stream in bits.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width per stream.
- ID_WIDTH, $clog2(NUM_INPUTS), width of m_axis_tid and grant_idx.

Ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous reset, active-low.
- s_axis_tdata  in  NUM_INPUTS*DATA_WIDTH  input i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tkeep  in  NUM_INPUTS*KEEP_WIDTH  packed the same way.
- s_axis_tvalid  in  NUM_INPUTS  per-input valid.
- s_axis_tlast  in  NUM_INPUTS  per-input last.
- s_axis_tready  out  NUM_INPUTS  per-input ready.
- m_axis_tdata  out  DATA_WIDTH  selected data.
- m_axis_tkeep  out  KEEP_WIDTH  selected keep.
- m_axis_tvalid  out  1  selected valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  selected last.
- m_axis_tid  out  ID_WIDTH  index of granted input.
- enable_mask  in  NUM_INPUTS  per-input arbitration enable; sampled only when a new grant is chosen.
- busy  out  1  high while a grant is held.
- grant_idx  out  ID_WIDTH  current/last granted index.

Behaviour:
- State machine has two states, IDLE and LOCKED. Registered signals: state, grant_idx, rr_ptr (ID_WIDTH).
- Reset (rst low, asynchronous) forces: state=IDLE, grant_idx=0, rr_ptr=0, busy=0. Consequently all s_axis_tready=0 and m_axis_tvalid=0 while reset is asserted.
- Request vector: req = s_axis_tvalid & enable_mask.
- Winner selection: the first set bit of req, scanning from rr_ptr upward and wrapping modulo NUM_INPUTS. The search is combinational.
- IDLE:
  - If req != 0: the next cycle enters LOCKED with grant_idx = winner.
  - Otherwise stay in IDLE.
  - Outputs are idle: m_axis_tvalid=0, all s_axis_tready=0.
  - Latency from first tvalid in IDLE to first m_axis_tvalid is 1 cycle.
- LOCKED (g = grant_idx) datapath, combinational:
  - m_axis_tdata/tkeep/tlast = lane g.
  - m_axis_tvalid = s_axis_tvalid[g].
  - m_axis_tid = g.
  - s_axis_tready[g] = m_axis_tready; every other s_axis_tready = 0.
  - busy=1.
  - enable_mask changes while LOCKED do not affect the current packet.
- End of packet: a beat is accepted when m_axis_tvalid & m_axis_tready & m_axis_tlast. On that cycle:
  - rr_ptr <= (g+1) mod NUM_INPUTS.
  - Re-arbitrate in the same cycle, searching from (g+1) mod NUM_INPUTS with the current req, masked so lane g is considered only if it is the sole requester.
  - If there is a winner, stay LOCKED with the new grant_idx (zero-bubble back-to-back packets). Otherwise go to IDLE.
- Fairness: with all inputs continuously requesting, grants rotate 0,1,...,N-1,0. No input waits more than N-1 packets.
- A single requester gets back-to-back packets with no idle cycle.
- Non-power-of-two NUM_INPUTS: the wrap compares against NUM_INPUTS-1, never 2^ID_WIDTH-1.
- Backpressure and source gaps:
  - m_axis_tready low holds all outputs stable, since the datapath is combinational from a held source.
  - A tvalid gap from the granted source keeps the grant; the arbiter never preempts mid-packet.
- Reset mid-packet: the packet is abandoned, with no tlast synthesised. After release, arbitration restarts from rr_ptr=0.
- No combinational path from m_axis_tready to m_axis_tvalid.
- No combinational path from s_axis_tvalid to s_axis_tready.

Test Plan:
- Reset: hold rst low with all inputs valid -> s_axis_tready=000, m_axis_tvalid=0, busy=0. Release -> input 0 granted 1 cycle later, m_axis_tid=0.
- Round-robin: N=3, all inputs issue continuous 2-beat packets (data 0xA0+i), m_axis_tready=1 -> output tid sequence 0,0,1,1,2,2,0,0. No idle cycle between packets. Each packet contiguous.
- Backpressure: input 1 alone sends 4-beat packet 0x11..0x14 with m_axis_tready toggling 1,0,1,0 -> output beats in order. Data stable while tready=0. tlast only on 0x14.
- Mask and non-preemption: mask=101, inputs 0 and 1 valid -> input 1 is never granted. Clear input 0's mask bit mid-packet -> the packet completes, then the arbiter goes IDLE (busy=0).
- Source gap: the granted input drops tvalid for 3 cycles mid-packet while input 2 is valid -> the grant is held, m_axis_tvalid=0 for 3 cycles, input 2 tready=0.
- Reset mid-packet: assert rst after beat 2 of a 5-beat packet -> outputs clear asynchronously. After release, a fresh arbitration occurs from index 0.
